// File: rtl/pipe_buffer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_buffer_ctrl_pkg
// Definitions shared by the pipeline-buffer controller and the hazard logic:
//   - buffer width and field bit positions of Buffer 1 / Buffer 2
//   - NOP opcode (loaded into bubbles) and the PSW register address
//   - the instruction-set opcodes this block needs to classify
//   - op_class(): ALU / MOV-to-A / other classification of an opcode
//   - pack_buffer(): assembles a buffer word from its fields
// -----------------------------------------------------------------------------
package pipe_buffer_ctrl_pkg;

    // Buffer layout, MSB to LSB: VALID | OPCODE | ADDR_OPERAND1 | OPERAND1 | OPERAND2 | CY
    localparam int BUFFER_LENGTH     = 34;
    localparam int VALID_POS         = 33;
    localparam int OPCODE_POS        = 25;  // [32:25]
    localparam int ADDR_OPERAND1_POS = 17;  // [24:17]
    localparam int OPERAND1_POS      = 9;   // [16:9]
    localparam int OPERAND2_POS      = 1;   // [8:1]
    localparam int CY_POS            = 0;

    localparam logic [7:0] NOP_OPCODE = 8'h00;
    localparam logic [7:0] PSW_ADDR   = 8'hFE;

    // Opcodes (IR[15:8])
    localparam logic [7:0] OP_ADD_R = 8'h01;
    localparam logic [7:0] OP_ADD_D = 8'h02;
    localparam logic [7:0] OP_ADC_R = 8'h03;
    localparam logic [7:0] OP_SUB_R = 8'h04;
    localparam logic [7:0] OP_AND_R = 8'h05;
    localparam logic [7:0] OP_OR_R  = 8'h06;
    localparam logic [7:0] OP_XOR_R = 8'h07;
    localparam logic [7:0] OP_MOV_R = 8'h10;
    localparam logic [7:0] OP_MOV_D = 8'h11;
    localparam logic [7:0] OP_MOV_C = 8'h12;
    localparam logic [7:0] OP_JMP   = 8'h20;
    localparam logic [7:0] OP_JC    = 8'h21;
    localparam logic [7:0] OP_JZ    = 8'h22;

    typedef enum logic [1:0] {
        CLASS_OTHER = 2'd0,
        CLASS_ALU   = 2'd1,
        CLASS_MOV   = 2'd2
    } op_class_e;

    typedef enum logic {
        SQ_RUN    = 1'b0,
        SQ_SQUASH = 1'b1
    } squash_state_e;

    // NOP falls into CLASS_OTHER, so a bubble never looks like a forwarding source.
    function automatic op_class_e op_class(input logic [7:0] opcode);
        op_class_e cls;
        case (opcode)
            OP_ADD_R, OP_ADD_D, OP_ADC_R, OP_SUB_R,
            OP_AND_R, OP_OR_R, OP_XOR_R:  cls = CLASS_ALU;
            OP_MOV_R, OP_MOV_D, OP_MOV_C: cls = CLASS_MOV;
            default:                      cls = CLASS_OTHER;
        endcase
        return cls;
    endfunction

    function automatic logic [BUFFER_LENGTH-1:0] pack_buffer(
        input logic       valid,
        input logic [7:0] opcode,
        input logic [7:0] addr_op1,
        input logic [7:0] operand1,
        input logic [7:0] operand2,
        input logic       cy
    );
        logic [BUFFER_LENGTH-1:0] b;
        b                             = '0;
        b[VALID_POS]                  = valid;
        b[OPCODE_POS +: 8]            = opcode;
        b[ADDR_OPERAND1_POS +: 8]     = addr_op1;
        b[OPERAND1_POS +: 8]          = operand1;
        b[OPERAND2_POS +: 8]          = operand2;
        b[CY_POS]                     = cy;
        return b;
    endfunction

endpackage

// File: rtl/pipe_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_buffer_ctrl_if
// Bundles the decode-stage instruction fields (into the buffer controller)
// and the register-file write-back port (out of the buffer controller).
//   master : decode / register-file side (drives i_*, receives o_wb_*)
//   slave  : pipe_buffer_ctrl (receives i_*, drives o_wb_*)
// -----------------------------------------------------------------------------
interface pipe_buffer_ctrl_if;

    // Decode stage
    logic       i_ir_valid;
    logic [7:0] i_opcode;
    logic [7:0] i_addr_op1;
    logic [7:0] i_operand1;
    logic [7:0] i_operand2;
    logic       i_cy;

    // Write-back port
    logic       o_wb_en;
    logic [7:0] o_wb_addr;
    logic [7:0] o_wb_data;
    logic       o_wb_cy_en;
    logic       o_wb_cy;

    modport master (
        output i_ir_valid, i_opcode, i_addr_op1, i_operand1, i_operand2, i_cy,
        input  o_wb_en, o_wb_addr, o_wb_data, o_wb_cy_en, o_wb_cy
    );

    modport slave (
        input  i_ir_valid, i_opcode, i_addr_op1, i_operand1, i_operand2, i_cy,
        output o_wb_en, o_wb_addr, o_wb_data, o_wb_cy_en, o_wb_cy
    );

endinterface

// File: rtl/pipe_squash_fsm.sv
// -----------------------------------------------------------------------------
// pipe_squash_fsm
// Two-state RUN/SQUASH machine. A taken branch (not stalled) moves to SQUASH
// for exactly one cycle, during which the decode-stage instruction is the
// wrong-path one and must be discarded.
// Ports:
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset (forces RUN)
//   i_pc_load  branch taken this cycle
//   i_stall    decode held; a stalled branch is re-presented, so no squash
//   o_squash   high while in SQUASH (state-register decode)
// -----------------------------------------------------------------------------
module pipe_squash_fsm
    import pipe_buffer_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pc_load,
    input  logic i_stall,
    output logic o_squash
);

    squash_state_e state_q, state_d;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SQ_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not assign state_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SQ_RUN:    if (i_pc_load && !i_stall) state_d = SQ_SQUASH;
            SQ_SQUASH: state_d = SQ_RUN;  // i_pc_load is ignored here
            default:   state_d = SQ_RUN;
        endcase
    end

    always_comb begin
        o_squash = (state_q == SQ_SQUASH);
    end

endmodule

// File: rtl/pipe_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_buffer_ctrl
// Owns Buffer 1 (execute) and Buffer 2 (write-back). Decode fields are
// captured into Buffer 1 each cycle and advance into Buffer 2 the next,
// with the ALU result / MOV source folded into OPERAND1 on the way.
// Taken branches squash the following decode slot; stalls inject bubbles.
// The register-file write-back port is driven combinationally from Buffer 2.
//
// Parameters: BUFFER_LENGTH (34), NOP_OPCODE (8'h00)
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   bus (slave)         decode fields in, write-back port out
//   i_stall             hold decode, bubble into Buffer 1
//   i_pc_load           branch taken this cycle
//   i_res_alu, i_cy_alu ALU result/carry for the Buffer 1 instruction
//   o_buffer1/2         pipeline registers (for the hazard logic)
//   o_squash            decode instruction is being discarded this cycle
// Optional feature, macro PIPE_STATS_EN:
//   o_retired[15:0]     saturating count of cycles with Buffer 2 VALID
//   o_bubbles[15:0]     saturating count of bubbles loaded into Buffer 1
// -----------------------------------------------------------------------------
module pipe_buffer_ctrl #(
    parameter int         BUFFER_LENGTH = pipe_buffer_ctrl_pkg::BUFFER_LENGTH,
    parameter logic [7:0] NOP_OPCODE    = pipe_buffer_ctrl_pkg::NOP_OPCODE
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    pipe_buffer_ctrl_if.slave        bus,
    input  logic                     i_stall,
    input  logic                     i_pc_load,
    input  logic [7:0]               i_res_alu,
    input  logic                     i_cy_alu,
    output logic [BUFFER_LENGTH-1:0] o_buffer1,
    output logic [BUFFER_LENGTH-1:0] o_buffer2,
    output logic                     o_squash
`ifdef PIPE_STATS_EN
    ,
    output logic [15:0]              o_retired,
    output logic [15:0]              o_bubbles
`endif
);

    import pipe_buffer_ctrl_pkg::*;

    localparam logic [BUFFER_LENGTH-1:0] BUBBLE =
        pack_buffer(1'b0, NOP_OPCODE, 8'h00, 8'h00, 8'h00, 1'b0);

    logic [BUFFER_LENGTH-1:0] buf1_q, buf1_d;
    logic [BUFFER_LENGTH-1:0] buf2_q, buf2_d;
    logic                     squash;
    op_class_e                buf1_class;
    op_class_e                buf2_class;

    pipe_squash_fsm u_squash_fsm (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pc_load (i_pc_load),
        .i_stall   (i_stall),
        .o_squash  (squash)
    );

    assign o_squash = squash;

    // Buffer 1: a taken jump itself is captured in RUN; only the slot after
    // it (seen while in SQUASH) is replaced by a bubble.
    always_comb begin
        buf1_d = BUBBLE;
        if (!squash && !i_stall && bus.i_ir_valid) begin
            buf1_d = pack_buffer(1'b1, bus.i_opcode, bus.i_addr_op1,
                                 bus.i_operand1, bus.i_operand2, bus.i_cy);
        end
    end

    // Buffer 2: copy of Buffer 1 with the write-back value placed in OPERAND1.
    // It always advances, so a stall drains the back of the pipe.
    always_comb begin
        buf1_class = op_class(buf1_q[OPCODE_POS +: 8]);
        buf2_d     = buf1_q;
        case (buf1_class)
            CLASS_ALU: begin
                buf2_d[OPERAND1_POS +: 8] = i_res_alu;
                buf2_d[CY_POS]            = i_cy_alu;
            end
            CLASS_MOV: buf2_d[OPERAND1_POS +: 8] = buf1_q[OPERAND2_POS +: 8];
            default:   ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            buf1_q <= BUBBLE;
            buf2_q <= BUBBLE;
        end else begin
            buf1_q <= buf1_d;
            buf2_q <= buf2_d;
        end
    end

    assign o_buffer1 = buf1_q;
    assign o_buffer2 = buf2_q;

    // Write-back port
    always_comb begin
        buf2_class = op_class(buf2_q[OPCODE_POS +: 8]);
    end

    assign bus.o_wb_en    = buf2_q[VALID_POS] &&
                            ((buf2_class == CLASS_ALU) || (buf2_class == CLASS_MOV));
    assign bus.o_wb_addr  = buf2_q[ADDR_OPERAND1_POS +: 8];
    assign bus.o_wb_data  = buf2_q[OPERAND1_POS +: 8];
    assign bus.o_wb_cy_en = buf2_q[VALID_POS] && (buf2_class == CLASS_ALU);
    assign bus.o_wb_cy    = buf2_q[CY_POS];

`ifdef PIPE_STATS_EN
    logic [15:0] retired_q, retired_d;
    logic [15:0] bubbles_q, bubbles_d;

    // Saturating counters; the reset branch below covers "outside reset".
    always_comb begin
        retired_d = retired_q;
        bubbles_d = bubbles_q;
        if (buf2_q[VALID_POS] && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end
        if (!buf1_d[VALID_POS] && (bubbles_q != 16'hFFFF)) begin
            bubbles_d = bubbles_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            retired_q <= 16'h0000;
            bubbles_q <= 16'h0000;
        end else begin
            retired_q <= retired_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign o_retired = retired_q;
    assign o_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_pipe_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_buffer_ctrl
// Self-checking bench for pipe_buffer_ctrl. Each driven cycle pushes the
// expected Buffer 2 / write-back record onto a scoreboard queue; the record
// is popped and compared one cycle later when it reaches Buffer 2.
// Optional macro PIPE_STATS_EN enables the statistics-counter test.
// -----------------------------------------------------------------------------
module tb_pipe_buffer_ctrl;

    import pipe_buffer_ctrl_pkg::*;

    localparam logic [33:0] TB_BUBBLE = {1'b0, 8'h00, 25'd0};

    typedef struct {
        logic       valid;
        logic [7:0] opc;
        logic [7:0] addr;
        logic [7:0] op1;
        logic [7:0] op2;
        logic       cy;
    } instr_t;

    typedef struct {
        logic [33:0] b2;
        logic [7:0]  res;
        logic        cyo;
        logic        wb_en;
        logic [7:0]  wb_addr;
        logic [7:0]  wb_data;
        logic        wb_cy_en;
        logic        wb_cy;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pc_load = 1'b0;
    logic [7:0]  res_alu = 8'h00;
    logic        cy_alu = 1'b0;
    logic [33:0] buffer1;
    logic [33:0] buffer2;
    logic        squash;
`ifdef PIPE_STATS_EN
    logic [15:0] retired;
    logic [15:0] bubbles;
`endif

    slot_t  sb_q[$];
    logic   model_sq = 1'b0;
    int     checks = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    pipe_buffer_ctrl_if bus ();

    pipe_buffer_ctrl #(
        .BUFFER_LENGTH (34),
        .NOP_OPCODE    (8'h00)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .bus       (bus),
        .i_stall   (stall),
        .i_pc_load (pc_load),
        .i_res_alu (res_alu),
        .i_cy_alu  (cy_alu),
        .o_buffer1 (buffer1),
        .o_buffer2 (buffer2),
        .o_squash  (squash)
`ifdef PIPE_STATS_EN
        ,
        .o_retired (retired),
        .o_bubbles (bubbles)
`endif
    );

    // 0 = other, 1 = ALU, 2 = MOV
    function automatic int tb_class(input logic [7:0] opc);
        int c;
        c = 0;
        if (opc == OP_ADD_R || opc == OP_ADD_D || opc == OP_ADC_R || opc == OP_SUB_R ||
            opc == OP_AND_R || opc == OP_OR_R  || opc == OP_XOR_R) c = 1;
        if (opc == OP_MOV_R || opc == OP_MOV_D || opc == OP_MOV_C) c = 2;
        return c;
    endfunction

    function automatic instr_t mk(input logic v, input logic [7:0] opc, input logic [7:0] addr,
                                  input logic [7:0] op1, input logic [7:0] op2, input logic cy);
        instr_t i;
        i.valid = v; i.opc = opc; i.addr = addr; i.op1 = op1; i.op2 = op2; i.cy = cy;
        return i;
    endfunction

    // Expected write-back record for a Buffer 1 word. Non-ALU slots get a
    // junk ALU result so a substitution on the wrong class is visible.
    function automatic slot_t make_slot(input logic [33:0] b1);
        slot_t      s;
        logic [8:0] sum;
        logic [7:0] op1;
        logic [7:0] op2;
        int         c;
        op1 = b1[16:9];
        op2 = b1[8:1];
        c   = tb_class(b1[32:25]);
        sum = {1'b0, op1} + {1'b0, op2};
        s.b2 = b1;
        if (c == 1) begin
            s.res      = sum[7:0];
            s.cyo      = sum[8];
            s.b2[16:9] = sum[7:0];
            s.b2[0]    = sum[8];
        end else begin
            s.res = op1 ^ 8'hA5;
            s.cyo = ~b1[0];
            if (c == 2) s.b2[16:9] = op2;
        end
        s.wb_en    = b1[33] && (c != 0);
        s.wb_addr  = b1[24:17];
        s.wb_data  = s.b2[16:9];
        s.wb_cy_en = b1[33] && (c == 1);
        s.wb_cy    = s.b2[0];
        return s;
    endfunction

    // Drive one decode cycle, advance one clock, score the result.
    task automatic run_cycle(input instr_t ins, input logic st, input logic pl,
                             input logic r, input string tag);
        logic [33:0] exp_b1;
        logic        exp_sq;
        slot_t       head;
        bus.i_ir_valid = ins.valid;
        bus.i_opcode   = ins.opc;
        bus.i_addr_op1 = ins.addr;
        bus.i_operand1 = ins.op1;
        bus.i_operand2 = ins.op2;
        bus.i_cy       = ins.cy;
        stall          = st;
        pc_load        = pl;
        rst            = r;
        head           = sb_q[0];
        res_alu        = head.res;
        cy_alu         = head.cyo;
        if (r || model_sq || st || !ins.valid) exp_b1 = TB_BUBBLE;
        else exp_b1 = {1'b1, ins.opc, ins.addr, ins.op1, ins.op2, ins.cy};
        exp_sq = r ? 1'b0 : (!model_sq && pl && !st);
        sb_q.push_back(make_slot(exp_b1));
        @(negedge clk);
        head = sb_q.pop_front();
        if (r) head = make_slot(TB_BUBBLE);
        model_sq = exp_sq;

        checks++;
        if (buffer1 !== exp_b1) begin
            failures++;
            $display("FAIL %s buffer1 actual=%h required=%h", tag, buffer1, exp_b1);
        end
        checks++;
        if (buffer2 !== head.b2) begin
            failures++;
            $display("FAIL %s buffer2 actual=%h required=%h", tag, buffer2, head.b2);
        end
        checks++;
        if (bus.o_wb_en !== head.wb_en) begin
            failures++;
            $display("FAIL %s wb_en actual=%b required=%b", tag, bus.o_wb_en, head.wb_en);
        end
        checks++;
        if (bus.o_wb_addr !== head.wb_addr) begin
            failures++;
            $display("FAIL %s wb_addr actual=%h required=%h", tag, bus.o_wb_addr, head.wb_addr);
        end
        checks++;
        if (bus.o_wb_data !== head.wb_data) begin
            failures++;
            $display("FAIL %s wb_data actual=%h required=%h", tag, bus.o_wb_data, head.wb_data);
        end
        checks++;
        if (bus.o_wb_cy_en !== head.wb_cy_en || bus.o_wb_cy !== head.wb_cy) begin
            failures++;
            $display("FAIL %s wb_cy actual=%b/%b required=%b/%b", tag,
                     bus.o_wb_cy_en, bus.o_wb_cy, head.wb_cy_en, head.wb_cy);
        end
        checks++;
        if (squash !== exp_sq) begin
            failures++;
            $display("FAIL %s squash actual=%b required=%b", tag, squash, exp_sq);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) run_cycle(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0), 0, 0, 0, tag);
    endtask

    task automatic test_reset();
        run_cycle(mk(1, OP_ADD_R, 8'h11, 8'h01, 8'h02, 1), 0, 1, 1, "reset0");
        run_cycle(mk(1, OP_ADD_R, 8'h11, 8'h01, 8'h02, 1), 0, 1, 1, "reset1");
        checks++;
        if (buffer1 !== 34'h0_0000_0000 || buffer2 !== 34'h0_0000_0000 ||
            bus.o_wb_en !== 1'b0 || squash !== 1'b0) begin
            failures++;
            $display("FAIL reset_state actual=%h/%h/%b/%b required=0/0/0/0",
                     buffer1, buffer2, bus.o_wb_en, squash);
        end
    endtask

    task automatic test_alu_mov();
        run_cycle(mk(1, OP_ADD_R, 8'h05, 8'h10, 8'h22, 1), 0, 0, 0, "add");
        checks++;
        if (buffer1 !== {1'b1, OP_ADD_R, 8'h05, 8'h10, 8'h22, 1'b1}) begin
            failures++;
            $display("FAIL add_buffer1 actual=%h", buffer1);
        end
        run_cycle(mk(1, OP_MOV_D, 8'h09, 8'h77, 8'h3C, 0), 0, 0, 0, "movd");
        checks++;
        if (bus.o_wb_en !== 1'b1 || bus.o_wb_addr !== 8'h05 || bus.o_wb_data !== 8'h32 ||
            bus.o_wb_cy_en !== 1'b1 || bus.o_wb_cy !== 1'b0) begin
            failures++;
            $display("FAIL add_wb actual=%b %h %h %b %b required=1 05 32 1 0", bus.o_wb_en,
                     bus.o_wb_addr, bus.o_wb_data, bus.o_wb_cy_en, bus.o_wb_cy);
        end
        run_cycle(mk(1, OP_ADD_D, 8'h06, 8'hF0, 8'h20, 0), 0, 0, 0, "addc");
        checks++;
        if (bus.o_wb_data !== 8'h3C || bus.o_wb_cy_en !== 1'b0 || bus.o_wb_en !== 1'b1) begin
            failures++;
            $display("FAIL movd_wb actual=%h %b required=3c 0", bus.o_wb_data, bus.o_wb_cy_en);
        end
        run_cycle(mk(1, OP_JZ, 8'h33, 8'h44, 8'h55, 0), 0, 0, 0, "jz_not_taken");
        run_cycle(mk(1, OP_MOV_C, 8'h08, 8'h00, 8'h99, 1), 0, 0, 0, "movc");
        run_cycle(mk(1, OP_MOV_R, 8'h0A, 8'h12, 8'h34, 0), 0, 0, 0, "movr");
        idle(2, "alu_drain");
    endtask

    task automatic test_squash();
        int hits_07 = 0;
        int sq_cycles = 0;
        run_cycle(mk(1, OP_JC, 8'h40, 8'h00, 8'h00, 1), 0, 1, 0, "jc");
        if (squash === 1'b1) sq_cycles++;
        run_cycle(mk(1, OP_MOV_D, 8'h07, 8'h00, 8'h5A, 0), 0, 1, 0, "squashed_movd");
        if (squash === 1'b1) sq_cycles++;
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(1, OP_ADD_R, 8'h01, 8'h02, 8'h03, 0), 0, 0, 0, "after_jc");
            if (squash === 1'b1) sq_cycles++;
            if (bus.o_wb_en === 1'b1 && bus.o_wb_addr === 8'h07) hits_07++;
        end
        checks++;
        if (sq_cycles != 1 || hits_07 != 0) begin
            failures++;
            $display("FAIL squash_window actual=%0d/%0d required=1/0", sq_cycles, hits_07);
        end
    endtask

    task automatic test_stall();
        instr_t x;
        int     x_seen = 0;
        int     stall_bubbles = 0;
        x = mk(1, OP_SUB_R, 8'h0C, 8'h80, 8'h81, 1);
        run_cycle(mk(1, OP_ADD_R, 8'h02, 8'h01, 8'h01, 0), 0, 0, 0, "pre_a");
        run_cycle(mk(1, OP_MOV_R, 8'h03, 8'h00, 8'h0F, 0), 0, 0, 0, "pre_b");
        for (int i = 0; i < 3; i++) begin
            run_cycle(x, 1, 0, 0, "stalled");
            if (buffer1 === TB_BUBBLE) stall_bubbles++;
        end
        for (int i = 0; i < 3; i++) begin
            run_cycle(i == 0 ? x : mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0), 0, 0, 0, "released");
            if (buffer1 === {1'b1, OP_SUB_R, 8'h0C, 8'h80, 8'h81, 1'b1}) x_seen++;
        end
        checks++;
        if (stall_bubbles != 3 || x_seen != 1) begin
            failures++;
            $display("FAIL stall_stream actual=%0d/%0d required=3/1", stall_bubbles, x_seen);
        end
    endtask

    task automatic test_stall_and_branch();
        instr_t jc;
        jc = mk(1, OP_JC, 8'h50, 8'h00, 8'h00, 1);
        run_cycle(jc, 1, 1, 0, "jc_stalled");
        checks++;
        if (squash !== 1'b0 || buffer1 !== TB_BUBBLE) begin
            failures++;
            $display("FAIL stall_wins actual=%b %h required=0 bubble", squash, buffer1);
        end
        run_cycle(jc, 0, 1, 0, "jc_represented");
        run_cycle(mk(1, OP_MOV_D, 8'h07, 8'h00, 8'h11, 0), 0, 0, 0, "jc_shadow");
        idle(2, "jc_drain");
    endtask

    task automatic test_reset_in_squash();
        run_cycle(mk(1, OP_JMP, 8'h60, 8'h00, 8'h00, 0), 0, 1, 0, "jmp");
        run_cycle(mk(1, OP_ADD_R, 8'h04, 8'h05, 8'h06, 0), 0, 1, 1, "rst_in_squash");
        checks++;
        if (squash !== 1'b0 || buffer1 !== TB_BUBBLE || buffer2 !== TB_BUBBLE) begin
            failures++;
            $display("FAIL rst_in_squash actual=%b %h %h required=0 bubble bubble",
                     squash, buffer1, buffer2);
        end
        run_cycle(mk(1, OP_ADD_R, 8'h04, 8'h05, 8'h06, 0), 0, 0, 0, "run_after_rst");
        idle(2, "rst_drain");
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [10];
        ops = '{OP_ADD_R, OP_ADD_D, OP_ADC_R, OP_XOR_R, OP_MOV_R,
                OP_MOV_D, OP_MOV_C, OP_JMP, OP_JC, OP_JZ};
        for (int i = 0; i < 60; i++) begin
            run_cycle(mk($urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)],
                         8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 0, "random");
        end
        idle(2, "random_drain");
    endtask

`ifdef PIPE_STATS_EN
    task automatic test_stats();
        run_cycle(mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 0), 0, 0, 1, "stats_rst");
        checks++;
        if (retired !== 16'h0000 || bubbles !== 16'h0000) begin
            failures++;
            $display("FAIL stats_clear actual=%h/%h required=0/0", retired, bubbles);
        end
        rst = 1'b0; stall = 1'b0; pc_load = 1'b0;
        bus.i_ir_valid = 1'b1; bus.i_opcode = OP_ADD_R; bus.i_addr_op1 = 8'h01;
        bus.i_operand1 = 8'h01; bus.i_operand2 = 8'h01; bus.i_cy = 1'b0;
        for (int i = 0; i < 70000; i++) @(negedge clk);
        checks++;
        if (retired !== 16'hFFFF || bubbles !== 16'h0000) begin
            failures++;
            $display("FAIL stats_saturate actual=%h/%h required=ffff/0000", retired, bubbles);
        end
    endtask
`endif

    initial begin
        #10_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_ir_valid = 1'b0;
        bus.i_opcode   = 8'h00;
        bus.i_addr_op1 = 8'h00;
        bus.i_operand1 = 8'h00;
        bus.i_operand2 = 8'h00;
        bus.i_cy       = 1'b0;
        sb_q.push_back(make_slot(TB_BUBBLE));
        @(negedge clk);
        test_reset();
        test_alu_mov();
        test_squash();
        test_stall();
        test_stall_and_branch();
        test_reset_in_squash();
        test_back_to_back();
`ifdef PIPE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
